// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the program RAM loader
package ram_pkg;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_FULL
    } ld_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_DEPTH  = 32;

    function automatic int bytes_per_word(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/prog_ram_loader_byte_packer.sv
// rtl/prog_ram_loader_byte_packer.sv - little-endian byte-to-word packer with zero-padded flush
module byte_packer
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYTE_W = DEF_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              data_valid,
    input  logic [BYTE_W-1:0] data_byte,
    input  logic              flush,
    output logic [DATA_W-1:0] word,
    output logic              commit
);
    localparam int BPW   = bytes_per_word(DATA_W, BYTE_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [DATA_W-1:0] lanes_q;
    logic [IDX_W-1:0]  idx_q;
    logic              take;

    assign take = enable && data_valid;

    // Lanes are cleared after every commit, so unfilled lanes are already zero on a flush.
    always_comb begin
        word = lanes_q;
        if (take) begin
            for (int i = 0; i < BPW; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    word[i*BYTE_W +: BYTE_W] = data_byte;
                end
            end
        end
    end

    assign commit = enable && ((take && idx_q == LAST_IDX) ||
                               (flush && (take || idx_q != '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (clear || commit) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (take) begin
            lanes_q <= word;
            idx_q   <= idx_q + IDX_ONE;
        end
    end

endmodule

// File: rtl/prog_ram_loader.sv
// rtl/prog_ram_loader.sv - program RAM with byte-serial loader and registered read port
module prog_ram_loader
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic              load_flush,
    output logic              load_busy,
    output logic              load_full,
    output logic              load_overflow,
    output logic [ADDR_W:0]   load_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $fatal(1, "prog_ram_loader: DATA_W must be a multiple of BYTE_W");
    end

    ld_state_t         state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   cnt_next;
    logic [DATA_W-1:0] pack_word;
    logic              pack_commit;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    byte_packer #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .enable     (state == LD_LOAD && !load_start),
        .data_valid (load_valid),
        .data_byte  (load_byte),
        .flush      (load_flush),
        .word       (pack_word),
        .commit     (pack_commit)
    );

    assign cnt_next = load_count + CNT_ONE;

    // load_start wins over everything else, including a commit in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LD_IDLE;
            wptr          <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
            load_busy     <= 1'b0;
            load_full     <= 1'b0;
        end else if (load_start) begin
            state         <= LD_LOAD;
            wptr          <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
            load_busy     <= 1'b1;
            load_full     <= 1'b0;
        end else begin
            case (state)
                LD_LOAD: begin
                    if (pack_commit) begin
                        wptr       <= wptr + PTR_ONE;
                        load_count <= cnt_next;
                        if (cnt_next == DEPTH_C) begin
                            state     <= LD_FULL;
                            load_busy <= 1'b0;
                            load_full <= 1'b1;
                        end
                    end
                end
                LD_FULL: begin
                    if (load_valid) begin
                        load_overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pack_commit) begin
            mem[wptr] <= pack_word;
        end
    end

    // Non-blocking write above makes a same-cycle read return the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;
            end
        end
    end

endmodule

// File: doc/prog_ram_loader.md
# prog_ram_loader

Parametrised program/data RAM with a built-in byte-serial loader. It replaces the fixed 32x32 memory with zero-extended byte writes. The loader packs `BYTES_PER_WORD` incoming bytes into full words and writes them to sequential addresses. An independent registered read port serves the fetch stage. The block sits between the external programming interface and the core's instruction fetch.

## Interface
Parameters:
- `DATA_W`, 32, word width; must be a multiple of `BYTE_W`.
- `BYTE_W`, 8, loader byte width.
- `DEPTH`, 32, number of words; need not be a power of two.
- `ADDR_W`, `$clog2(DEPTH)`, read address width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  pulse; restart loading at word 0 and clear flags.
- `load_valid`  in  1  `load_byte` is valid this cycle.
- `load_byte`  in  `BYTE_W`  serial program byte.
- `load_flush`  in  1  pulse; commit a partial word, zero-padded.
- `load_busy`  out  1  loader in LOAD state.
- `load_full`  out  1  `DEPTH` words committed.
- `load_overflow`  out  1  sticky; a byte arrived while FULL.
- `load_count`  out  `ADDR_W+1`  words committed since the last start.
- `rd_en`  in  1  read request.
- `rd_addr`  in  `ADDR_W`  word address.
- `rd_data`  out  `DATA_W`  read data.
- `rd_valid`  out  1  `rd_data` valid.

## Operation
- FSM states: IDLE, LOAD, FULL. Reset state is IDLE.
- IDLE to LOAD: on `load_start`. Word pointer, byte index and `load_count` go to 0. `load_overflow` clears.
- LOAD, `load_valid`: the byte goes into lane `byte_idx`, little-endian (first byte lands in bits `[BYTE_W-1:0]`).
  - If `byte_idx` is the last lane, the assembled word is written to `mem[wptr]`.
  - On that write, `wptr` and `load_count` increment and `byte_idx` wraps to 0.
- LOAD, `load_flush` with `byte_idx`≠0: the partial word is committed with unfilled lanes set to 0. This counts as one word.
- LOAD, `load_flush` with `byte_idx`=0: no effect.
- `load_flush` and `load_valid` in the same cycle: the byte is packed first, then the result is flushed.
- LOAD to FULL: when a commit makes `load_count`=`DEPTH`.
- FULL: `load_valid` bytes are dropped and set `load_overflow`. `load_flush` is ignored.
- FULL to LOAD: on `load_start`.
- IDLE: `load_valid` and `load_flush` are ignored.
- `load_start` has priority over any same-cycle `load_valid` or `load_flush`; that byte is dropped.
- Read port:
  - `rd_en` registers `mem[rd_addr]` into `rd_data`.
  - `rd_valid` is asserted the next cycle.
  - Reads are allowed in every state.
  - `rd_addr` ≥ `DEPTH` returns 0 with `rd_valid`=1.
  - Without `rd_en`, `rd_valid`=0 and `rd_data` holds its last value.
- Memory array is not reset. It is initialised to 0 at elaboration.

## Timing
- Reset values: `load_busy`=0, `load_full`=0, `load_overflow`=0, `load_count`=0, `rd_data`=0, `rd_valid`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-load: any partially packed word is discarded. Words already committed remain in the array.
- Write latency: the word is in the array after the edge that samples its last byte. A read issued the next cycle sees it.
- Read latency: 1 cycle from `rd_en` to `rd_valid`/`rd_data`. Throughput is 1 read per cycle.
- Same-cycle commit and read of the same address: the read returns the old contents (read-before-write).
- `load_full` rises on the edge of the final commit. `load_busy` falls on the same edge.

## Structure
- Shared package `ram_pkg`:
  - loader state enum (`LD_IDLE`, `LD_LOAD`, `LD_FULL`);
  - default width constants;
  - a `BYTES_PER_WORD` localparam function.
- One sub-module, `byte_packer`: byte-lane register, lane index, zero-padding flush. It emits `word` plus a `commit` pulse.
- Top level holds the FSM, pointer, array and read port.
- Elaboration check: `DATA_W % BYTE_W == 0`, otherwise fatal.

## Test plan
- Reset, then pulse `load_start`. Send bytes 0x11,0x22,0x33,0x44. Expect `mem[0]`=0x44332211 and `load_count`=1. `rd_en` with addr 0 the next cycle gives `rd_data`=0x44332211 and `rd_valid`=1 one cycle later.
- Send bytes 0xAA,0xBB, then `load_flush`. Expect `mem[1]`=0x0000BBAA and `load_count`=2. A second `load_flush` changes nothing.
- Load 128 bytes (`DEPTH`=32). Expect `load_full`=1 and `load_busy`=0. A 129th byte sets `load_overflow`, and `mem[0]`..`mem[31]` are unchanged.
- Read addr 5 in the same cycle as the commit to word 5 (old value 0, new value 0xDEADBEEF). The read returns 0; a read on the next cycle returns 0xDEADBEEF.
- Assert `rst` after 2 bytes of a word. All outputs return to their reset values. After `load_start` and bytes 1,2,3,4, expect `mem[0]`=0x04030201.
- Reads with `rd_addr`=31 and with a non-power-of-two `DEPTH`=20 at addr 25. The out-of-range read returns 0 with `rd_valid`=1. `load_start` and `load_valid` in the same cycle: the byte is dropped and `load_count`=0.
